// File: rtl/feature_tx_pkg.sv
// Shared constants, FSM state type and beat packing for feature_frame_tx.
package feature_tx_pkg;

  localparam int unsigned NUM_BEATS = 5;
  localparam int unsigned CHUNK_W   = 5;
  localparam int unsigned POS_W     = 3;
  localparam int unsigned FEAT_W    = 25;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StSend,
    StSettle,
    StCapture
  } state_e;

  // Beat layout on ui_in: chunk bits reversed (c[0] at MSB), beat position in the low bits.
  function automatic logic [CHUNK_W+POS_W-1:0] pack_beat(input logic [CHUNK_W-1:0] chunk,
                                                         input logic [POS_W-1:0]   pos);
    logic [CHUNK_W-1:0] rev;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      rev[i] = chunk[CHUNK_W-1-i];
    end
    return {rev, pos};
  endfunction

endpackage

// File: rtl/feature_frame_tx.sv
// Frame driver for the decision-tree core: reset pulse, five feature beats, settle, capture.
// Optional result capture is enabled by defining FEATURE_FRAME_TX_RESULT_EN; without it the
// CAPTURE state still runs (same stream timing) but res_valid/res_data are tied low.
module feature_frame_tx
  import feature_tx_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 1,
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [24:0] s_feat,
  output logic [7:0]  tx_word,
  output logic        tx_rst_n,
  input  logic [7:0]  dut_out,
  output logic        res_valid,
  output logic [7:0]  res_data
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [FEAT_W-1:0]  feat_q, feat_d;
  logic [7:0]         tx_word_q, tx_word_d;
  logic               tx_rst_n_q, tx_rst_n_d;
  logic               s_ready_q, s_ready_d;
  logic               capture_fire;
  logic               accept;

  function automatic logic [CHUNK_W-1:0] chunk_at(input logic [FEAT_W-1:0] f,
                                                  input logic [POS_W-1:0]  p);
    return f[CHUNK_W*p +: CHUNK_W];
  endfunction

  // s_ready_q is only high in IDLE and CAPTURE, so it doubles as the acceptance window.
  assign accept = s_valid && s_ready_q;

  // Next-state and registered-output logic; the down-counter is shared by RST and SETTLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    feat_d       = feat_q;
    tx_word_d    = tx_word_q;
    tx_rst_n_d   = tx_rst_n_q;
    s_ready_d    = s_ready_q;
    capture_fire = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_ready_d = 1'b1;
      end
      StRst: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = StSend;
          pos_d      = '0;
          tx_word_d  = pack_beat(chunk_at(feat_q, '0), '0);
          tx_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSend: begin
        if (pos_q == POS_W'(NUM_BEATS - 1)) begin
          // Last beat stays on the bus through settle and idle.
          state_d = StSettle;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
        end else begin
          pos_d     = pos_q + POS_W'(1);
          tx_word_d = pack_beat(chunk_at(feat_q, pos_q + POS_W'(1)), pos_q + POS_W'(1));
        end
      end
      StSettle: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = StCapture;
          s_ready_d    = 1'b1;
          capture_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StCapture: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Acceptance overrides the IDLE/CAPTURE defaults above.
    if (accept) begin
      state_d    = StRst;
      feat_d     = s_feat;
      cnt_d      = CNT_W'(RST_CYCLES);
      tx_rst_n_d = 1'b0;
      tx_word_d  = '0;
      s_ready_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pos_q      <= '0;
      feat_q     <= '0;
      tx_word_q  <= '0;
      tx_rst_n_q <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      feat_q     <= feat_d;
      tx_word_q  <= tx_word_d;
      tx_rst_n_q <= tx_rst_n_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign tx_word  = tx_word_q;
  assign tx_rst_n = tx_rst_n_q;
  assign s_ready  = s_ready_q;

`ifdef FEATURE_FRAME_TX_RESULT_EN
  logic       res_valid_q;
  logic [7:0] res_data_q;

  // Sample the core output on the final settle edge; valid pulses during CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= capture_fire;
      if (capture_fire) begin
        res_data_q <= dut_out;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`else
  logic unused_result;

  assign unused_result = ^{dut_out, capture_fire};
  assign res_valid     = 1'b0;
  assign res_data      = '0;
`endif

endmodule

// File: tb/tb_feature_frame_tx.sv
// Self-checking bench for feature_frame_tx: default-parameter instance plus a short-timing one.
module tb_feature_frame_tx;

`ifdef FEATURE_FRAME_TX_RESULT_EN
  localparam logic EXP_RV = 1'b1;
`else
  localparam logic EXP_RV = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [24:0] s_feat;
  logic [7:0]  tx_word, dut_out, res_data;
  logic        tx_rst_n, res_valid;

  logic        s_valid1, s_ready1;
  logic [24:0] s_feat1;
  logic [7:0]  tx_word1, dut_out1, res_data1;
  logic        tx_rst_n1, res_valid1;

  int checks = 0;
  int errors = 0;

  logic [7:0] beat_q[$];
  logic [7:0] res_q[$];

  feature_frame_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_feat    (s_feat),
    .tx_word   (tx_word),
    .tx_rst_n  (tx_rst_n),
    .dut_out   (dut_out),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  feature_frame_tx #(
    .RST_CYCLES    (3),
    .SETTLE_CYCLES (1)
  ) dut_short (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid1),
    .s_ready   (s_ready1),
    .s_feat    (s_feat1),
    .tx_word   (tx_word1),
    .tx_rst_n  (tx_rst_n1),
    .dut_out   (dut_out1),
    .res_valid (res_valid1),
    .res_data  (res_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference beat: chunk k bit-reversed above the 3-bit position k.
  function automatic logic [7:0] ref_beat(input logic [24:0] f, input int k);
    logic [4:0] c;
    c = f[5*k +: 5];
    return {c[0], c[1], c[2], c[3], c[4], 3'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [24:0] f, input logic [7:0] dout);
    for (int k = 0; k < 5; k++) beat_q.push_back(ref_beat(f, k));
    res_q.push_back(EXP_RV ? dout : 8'h00);
  endtask

  // Entered in cycle 1 after acceptance; leaves in the CAPTURE cycle (cycle 12).
  task automatic expect_frame(input string name);
    logic [10:0] obs, exp;
    logic [7:0]  last, rexp;
    last = 8'h00;
    checks++;
    obs = {tx_rst_n, s_ready, res_valid, tx_word};
    exp = {1'b0, 1'b0, 1'b0, 8'h00};
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s rst_cycle {rst_n,rdy,rv,word} got %h want %h", name, obs, exp);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (beat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s beat scoreboard empty got 0 want 1 entries", name);
      end else begin
        last = beat_q.pop_front();
        checks++;
        obs = {tx_rst_n, s_ready, res_valid, tx_word};
        exp = {1'b1, 1'b0, 1'b0, last};
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s beat cycle %0d got %h want %h", name, c, obs, exp);
        end
      end
    end
    for (int c = 7; c <= 11; c++) begin
      tick();
      checks++;
      obs = {tx_rst_n, s_ready, res_valid, tx_word};
      exp = {1'b1, 1'b0, 1'b0, last};
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s settle cycle %0d got %h want %h", name, c, obs, exp);
      end
    end
    tick();
    if (res_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s result scoreboard empty got 0 want 1 entries", name);
    end else begin
      rexp = res_q.pop_front();
      checks++;
      obs = {tx_rst_n, s_ready, res_valid, tx_word};
      exp = {1'b1, 1'b1, EXP_RV, last};
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s capture cycle got %h want %h", name, obs, exp);
      end
      checks++;
      if (res_data !== rexp) begin
        errors++;
        $display("FAIL %s res_data got %h want %h", name, res_data, rexp);
      end
    end
  endtask

  task automatic expect_idle(input string name, input logic [7:0] word, input int n);
    logic [10:0] obs, exp;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      obs = {tx_rst_n, s_ready, res_valid, tx_word};
      exp = {1'b1, 1'b1, 1'b0, word};
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s idle cycle %0d got %h want %h", name, i, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] obs, exp;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    obs = {tx_rst_n, s_ready, res_valid, tx_word};
    if (obs !== 11'h000 || res_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got %h/%h want 000/00", obs, res_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      obs = {tx_rst_n, s_ready, res_valid, tx_word};
      exp = {1'b0, 1'b1, 1'b0, 8'h00};
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d got %h want %h", i, obs, exp);
      end
    end
    checks++;
    if ({tx_rst_n1, s_ready1, res_valid1} !== 3'b010) begin
      errors++;
      $display("FAIL short_idle got %b want 010", {tx_rst_n1, s_ready1, res_valid1});
    end
  endtask

  task automatic test_all_ones();
    dut_out = 8'h03;
    s_feat  = 25'h1FFFFFF;
    s_valid = 1'b1;
    push_frame(s_feat, dut_out);
    tick();
    s_valid = 1'b0;
    s_feat  = 25'h0;
    expect_frame("all_ones");
    expect_idle("all_ones", 8'hFC, 4);
  endtask

  task automatic test_chunk0();
    dut_out = 8'hA5;
    s_feat  = 25'h0000016;
    s_valid = 1'b1;
    push_frame(s_feat, dut_out);
    tick();
    s_valid = 1'b0;
    s_feat  = 25'h1555555;
    expect_frame("chunk0");
    expect_idle("chunk0", 8'h04, 2);
  endtask

  task automatic test_back_to_back();
    dut_out = 8'h5C;
    s_feat  = 25'h155AAAA;
    s_valid = 1'b1;
    push_frame(s_feat, dut_out);
    tick();
    s_feat = 25'h0ABCDE1;
    expect_frame("b2b_first");
    push_frame(s_feat, 8'hC3);
    tick();
    dut_out = 8'hC3;
    s_valid = 1'b0;
    expect_frame("b2b_second");
    expect_idle("b2b_second", ref_beat(25'h0ABCDE1, 4), 2);
  endtask

  task automatic test_mid_reset();
    logic [10:0] obs, exp;
    logic [24:0] f;
    f       = 25'h1234567;
    dut_out = 8'h99;
    s_feat  = f;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_word !== ref_beat(f, 2)) begin
      errors++;
      $display("FAIL mid_reset_beat2 got %h want %h", tx_word, ref_beat(f, 2));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    obs = {tx_rst_n, s_ready, res_valid, tx_word};
    if (obs !== 11'h000 || res_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async got %h/%h want 000/00", obs, res_data);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      obs = {tx_rst_n, s_ready, res_valid, tx_word};
      exp = {1'b0, 1'b1, 1'b0, 8'h00};
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_drop cycle %0d got %h want %h", i, obs, exp);
      end
    end
    dut_out = 8'h4D;
    s_feat  = 25'h0C3A5F1;
    s_valid = 1'b1;
    push_frame(s_feat, dut_out);
    tick();
    s_valid = 1'b0;
    expect_frame("after_reset");
    expect_idle("after_reset", ref_beat(25'h0C3A5F1, 4), 2);
  endtask

  task automatic test_params();
    logic [10:0] obs, exp;
    logic [24:0] f;
    logic [7:0]  last;
    f        = 25'h0F0F0F0;
    dut_out1 = 8'h7E;
    s_feat1  = f;
    s_valid1 = 1'b1;
    tick();
    s_valid1 = 1'b0;
    s_feat1  = 25'h0;
    last     = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      if (c >= 4 && c <= 8) last = ref_beat(f, c - 4);
      if (c <= 3)       exp = {1'b0, 1'b0, 1'b0, 8'h00};
      else if (c <= 9)  exp = {1'b1, 1'b0, 1'b0, last};
      else              exp = {1'b1, 1'b1, EXP_RV, last};
      checks++;
      obs = {tx_rst_n1, s_ready1, res_valid1, tx_word1};
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_params cycle %0d got %h want %h", c, obs, exp);
      end
      if (c < 10) tick();
    end
    checks++;
    if (res_data1 !== (EXP_RV ? 8'h7E : 8'h00)) begin
      errors++;
      $display("FAIL short_res_data got %h want %h", res_data1, EXP_RV ? 8'h7E : 8'h00);
    end
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_feat   = '0;
    dut_out  = '0;
    s_valid1 = 1'b0;
    s_feat1  = '0;
    dut_out1 = '0;
    test_reset();
    test_all_ones();
    test_chunk0();
    test_back_to_back();
    test_mid_reset();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
